// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// Holds the FSM encoding, captured-request payload, word-index shift and default init words.
package dmem_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WORD_SHIFT = 1;
    localparam int unsigned WIDX_W     = ADDR_W - WORD_SHIFT;

    localparam logic [DATA_W-1:0] DEF_INIT_W0 = 16'd5;
    localparam logic [DATA_W-1:0] DEF_INIT_W1 = 16'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        logic [WIDX_W-1:0] widx;
        widx = WIDX_W'(addr >> WORD_SHIFT);
        return addr[0] | (32'(widx) >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU load/store unit and the data memory.
// master = CPU side, slave = memory side.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH x 16 word store: synchronous write, asynchronous read.
// Words 0 and 1 power up to INIT_W0/INIT_W1, all others to zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned       DEPTH   = 1024,
    parameter int unsigned       AW      = 10,
    parameter logic [DATA_W-1:0] INIT_W0 = DEF_INIT_W0,
    parameter logic [DATA_W-1:0] INIT_W1 = DEF_INIT_W1
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH] = '{0: INIT_W0, 1: INIT_W1, default: '0};

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one lw/sw at a time, fixed wait states, then a held response.
// IDLE -> WAIT (WAIT_CYCLES) -> ACCESS (1) -> RESP until resp_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       DEPTH       = 1024,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] INIT_W0     = DEF_INIT_W0,
    parameter logic [DATA_W-1:0] INIT_W1     = DEF_INIT_W1
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            r_state;
    req_t              r_req;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_error;

    logic [WIDX_W-1:0] w_word_idx;
    logic              w_err;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    assign w_word_idx = WIDX_W'(r_req.addr >> WORD_SHIFT);
    assign w_err      = addr_error(r_req.addr, DEPTH);
    // Reset outranks the commit so an interrupted store never lands.
    assign w_we       = (r_state == ST_ACCESS) & r_req.write & ~w_err & ~reset;

    dmem_array #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .INIT_W0 (INIT_W0),
        .INIT_W1 (INIT_W1)
    ) u_array (
        .clock   (clock),
        .i_we    (w_we),
        .i_addr  (AW'(w_word_idx)),
        .i_wdata (r_req.wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_req       <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_error <= w_err;
                    r_resp_rdata <= (w_err | r_req.write) ? '0 : w_rdata;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_error <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_error = r_resp_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one WAIT_CYCLES=2 instance and one WAIT_CYCLES=0 instance.
// Cycle 1 is the cycle right after the accepting edge; responses are expected in cycle WAIT_CYCLES+2.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .INIT_W0(16'd5), .INIT_W1(16'd7)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .INIT_W0(16'd5), .INIT_W1(16'd7)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input virtual dmem_responder_if vif, input string tag);
        chk({tag, "_req_ready"},  32'(vif.req_ready),  32'd1);
        chk({tag, "_resp_valid"}, 32'(vif.resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, 32'(vif.resp_rdata), 32'd0);
        chk({tag, "_resp_error"}, 32'(vif.resp_error), 32'd0);
    endtask

    // Present one request at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input virtual dmem_responder_if vif, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata, input string tag);
        vif.req_valid = 1'b1;
        vif.req_write = wr;
        vif.req_addr  = addr;
        vif.req_wdata = wdata;
        chk({tag, "_accept_ready"}, 32'(vif.req_ready), 32'd1);
        @(negedge clock);
        vif.req_valid = 1'b0;
        vif.req_addr  = 16'hFFFF;
        vif.req_wdata = 16'hFFFF;
        chk({tag, "_busy_ready"}, 32'(vif.req_ready), 32'd0);
    endtask

    task automatic wait_resp(input virtual dmem_responder_if vif, input int exp_lat, input string tag);
        int k;
        k = 1;
        while (vif.resp_valid !== 1'b1 && k < 30) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    endtask

    task automatic complete(input virtual dmem_responder_if vif, input string tag);
        vif.resp_ready = 1'b1;
        @(negedge clock);
        vif.resp_ready = 1'b0;
        chk_idle(vif, {tag, "_done"});
    endtask

    task automatic txn(input virtual dmem_responder_if vif, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input int exp_lat, input logic [15:0] exp_rdata,
                       input logic exp_err, input string tag);
        issue(vif, wr, addr, wdata, tag);
        wait_resp(vif, exp_lat, tag);
        chk({tag, "_rdata"}, 32'(vif.resp_rdata), 32'(exp_rdata));
        chk({tag, "_error"}, 32'(vif.resp_error), 32'(exp_err));
        complete(vif, tag);
    endtask

    initial begin
        reset = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_idle(bus2, "reset2");
        chk_idle(bus0, "reset0");

        // Power-up word 1, then store/load round trip.
        txn(bus2, 1'b0, 16'h0002, 16'h0000, 4, 16'd7,    1'b0, "load_w1");
        txn(bus2, 1'b1, 16'h0004, 16'h1234, 4, 16'h0000, 1'b0, "store_w2");
        txn(bus2, 1'b0, 16'h0004, 16'h0000, 4, 16'h1234, 1'b0, "load_w2");

        // Error cases and array boundary.
        txn(bus2, 1'b0, 16'h0003, 16'h0000, 4, 16'h0000, 1'b1, "load_misalign");
        txn(bus2, 1'b0, 16'h0800, 16'h0000, 4, 16'h0000, 1'b1, "load_w1024");
        txn(bus2, 1'b0, 16'hFFFE, 16'h0000, 4, 16'h0000, 1'b1, "load_fffe");
        txn(bus2, 1'b1, 16'h0003, 16'hFFFF, 4, 16'h0000, 1'b1, "store_misalign");
        txn(bus2, 1'b0, 16'h0002, 16'h0000, 4, 16'd7,    1'b0, "load_w1_after");
        txn(bus2, 1'b0, 16'h07FE, 16'h0000, 4, 16'h0000, 1'b0, "load_w1023");

        // Stalled response while the request inputs churn.
        issue(bus2, 1'b0, 16'h0000, 16'h0000, "stall");
        wait_resp(bus2, 4, "stall");
        for (int c = 0; c < 5; c++) begin
            bus2.req_valid = 1'b1;
            bus2.req_write = c[0];
            bus2.req_addr  = 16'(c * 2);
            bus2.req_wdata = 16'hDEAD;
            @(negedge clock);
            chk("stall_valid", 32'(bus2.resp_valid), 32'd1);
            chk("stall_rdata", 32'(bus2.resp_rdata), 32'd5);
            chk("stall_ready", 32'(bus2.req_ready),  32'd0);
        end
        bus2.req_valid = 1'b0;
        complete(bus2, "stall");
        txn(bus2, 1'b0, 16'h0000, 16'h0000, 4, 16'd5, 1'b0, "load_w0_after_stall");

        // resp_ready held high before the response exists.
        bus2.resp_ready = 1'b1;
        issue(bus2, 1'b0, 16'h0004, 16'h0000, "early_ready");
        wait_resp(bus2, 4, "early_ready");
        chk("early_ready_rdata", 32'(bus2.resp_rdata), 32'h1234);
        @(negedge clock);
        bus2.resp_ready = 1'b0;
        chk_idle(bus2, "early_ready_done");

        // Reset in WAIT abandons the store.
        issue(bus2, 1'b1, 16'h0000, 16'hBEEF, "rst_wait");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_idle(bus2, "rst_wait");
        txn(bus2, 1'b0, 16'h0000, 16'h0000, 4, 16'd5, 1'b0, "load_w0_rst_wait");

        // Reset in ACCESS (cycle 3) blocks the commit.
        issue(bus2, 1'b1, 16'h0000, 16'hBEEF, "rst_access");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_idle(bus2, "rst_access");
        txn(bus2, 1'b0, 16'h0000, 16'h0000, 4, 16'd5, 1'b0, "load_w0_rst_access");

        // Zero-wait instance at the last legal word.
        txn(bus0, 1'b1, 16'h07FE, 16'hAAAA, 2, 16'h0000, 1'b0, "w0_store_w1023");
        txn(bus0, 1'b0, 16'h07FE, 16'h0000, 2, 16'hAAAA, 1'b0, "w0_load_w1023");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
